// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART transmitter: queues bytes and issues one
// send_trig/send_data pulse per byte, pacing pops on the tx_bsy handshake.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  input  logic          flush,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          send_trig,
  output logic [7:0]    send_data,
  input  logic          tx_bsy,
  output logic [1:0]    dbg_state_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    TRIG      = 2'd1,
    WAIT_BSY  = 2'd2,
    WAIT_DONE = 2'd3
  } state_e;

  // Handshake: a byte is handed over by a one-cycle send_trig while tx_bsy=0;
  // the transmitter then raises tx_bsy for the frame and drops it when done.
  state_e          state_q;
  logic [7:0]      mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_d;
  logic            overflow_q;
  logic            send_trig_q;
  logic [7:0]      send_data_q;
  logic            wr_ok;
  logic            pop;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign count       = count_q;
  assign overflow    = overflow_q;
  assign send_trig   = send_trig_q;
  assign send_data   = send_data_q;
  assign dbg_state_o = state_q;

  // full is judged on the registered count, so a same-edge pop never frees a slot
  always_comb begin
    wr_ok   = wr_en && !full && !flush;
    pop     = !flush && !empty && !tx_bsy &&
              ((state_q == IDLE) || (state_q == WAIT_DONE));
    count_d = count_q + CW'(wr_ok) - CW'(pop);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      send_trig_q <= 1'b0;
      send_data_q <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      overflow_q  <= wr_en && full && !flush;
      send_trig_q <= pop;

      if (wr_ok) begin
        mem_q[wr_ptr_q] <= wr_data;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        send_data_q <= mem_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + 1'b1;
      end

      // flush clears only the queue; an already popped byte keeps its FSM path
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
      end else begin
        count_q <= count_d;
      end

      case (state_q)
        IDLE:      if (pop) state_q <= TRIG;
        TRIG:      state_q <= WAIT_BSY;
        WAIT_BSY:  if (tx_bsy) state_q <= WAIT_DONE;
        WAIT_DONE: if (!tx_bsy) state_q <= pop ? TRIG : IDLE;
        default:   state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo (DEPTH=4) with a behavioural transmitter
// that holds tx_bsy for a fixed frame length after each accepted trig.
module tb_uart_tx_fifo;

  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int FRAME = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          flush = 1'b0;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          send_trig;
  logic [7:0]    send_data;
  logic          tx_bsy;
  logic [1:0]    dbg_state;

  logic          bsy_q;
  int            frame_cnt;
  logic          hold_bsy = 1'b0;
  logic          prev_trig = 1'b0;
  logic [7:0]    exp_q[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            n_trigs = 0;
  int            trig_snap;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .flush       (flush),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .overflow    (overflow),
    .send_trig   (send_trig),
    .send_data   (send_data),
    .tx_bsy      (tx_bsy),
    .dbg_state_o (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  assign tx_bsy = bsy_q | hold_bsy;

  // transmitter model: accepts a trig seen while idle, busy for FRAME cycles
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bsy_q     <= 1'b0;
      frame_cnt <= 0;
    end else if (!tx_bsy && send_trig) begin
      bsy_q     <= 1'b1;
      frame_cnt <= FRAME;
    end else if (bsy_q) begin
      if (frame_cnt == 1) bsy_q <= 1'b0;
      frame_cnt <= frame_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // scoreboard and protocol monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (send_trig) begin
        n_trigs++;
        check("trig_while_bsy", {31'd0, tx_bsy}, 32'd0);
        check("trig_back_to_back", {31'd0, prev_trig}, 32'd0);
        check("frame_data", {24'd0, send_data},
              (exp_q.size() != 0) ? {24'd0, exp_q.pop_front()} : 32'h1DEAD);
      end
      prev_trig = send_trig;
    end else begin
      prev_trig = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      tick();
      if (!tx_bsy && dbg_state == 2'd0 && empty && !send_trig) done = 1'b1;
    end
    check("wait_idle", {31'd0, done}, 32'd1);
  endtask

  initial begin
    // 1: reset and idle
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rst_empty", {31'd0, empty}, 32'd1);
    check("rst_full", {31'd0, full}, 32'd0);
    check("rst_count", {29'd0, count}, 32'd0);
    check("rst_trig", {31'd0, send_trig}, 32'd0);
    check("rst_data", {24'd0, send_data}, 32'h00);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);

    // 2: single byte latency
    exp_q.push_back(8'hA5);
    write_byte(8'hA5);
    check("t2_count_n", {29'd0, count}, 32'd1);
    check("t2_trig_n", {31'd0, send_trig}, 32'd0);
    tick();
    check("t2_trig_n1", {31'd0, send_trig}, 32'd1);
    check("t2_data_n1", {24'd0, send_data}, 32'hA5);
    check("t2_count_n1", {29'd0, count}, 32'd0);
    tick();
    check("t2_trig_n2", {31'd0, send_trig}, 32'd0);
    check("t2_bsy_n2", {31'd0, tx_bsy}, 32'd1);
    check("t2_data_hold", {24'd0, send_data}, 32'hA5);
    wait_idle();

    // 3/4: burst to full while transmitter held busy, then overflow
    hold_bsy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      write_byte(8'(i + 1));
      check("t3_count", {29'd0, count}, 32'(i + 1));
      check("t3_no_ovf", {31'd0, overflow}, 32'd0);
    end
    check("t3_full", {31'd0, full}, 32'd1);
    write_byte(8'hFF);
    check("t4_ovf_pulse", {31'd0, overflow}, 32'd1);
    check("t4_count_held", {29'd0, count}, 32'd4);
    tick();
    check("t4_ovf_drop", {31'd0, overflow}, 32'd0);
    check("t4_full_still", {31'd0, full}, 32'd1);
    for (int i = 0; i < DEPTH; i++) exp_q.push_back(8'(i + 1));
    hold_bsy = 1'b0;
    wait_idle();

    // 5: flush during first frame
    exp_q.push_back(8'h10);
    write_byte(8'h10);
    write_byte(8'h11);
    write_byte(8'h12);
    check("t5_count", {29'd0, count}, 32'd2);
    check("t5_bsy", {31'd0, tx_bsy}, 32'd1);
    trig_snap = n_trigs;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("t5_flush_count", {29'd0, count}, 32'd0);
    check("t5_flush_empty", {31'd0, empty}, 32'd1);
    wait_idle();
    repeat (20) tick();
    check("t5_no_more_trig", 32'(n_trigs), 32'(trig_snap));

    // 6: async reset mid-frame with three bytes queued
    exp_q.push_back(8'h20);
    write_byte(8'h20);
    write_byte(8'h21);
    write_byte(8'h22);
    write_byte(8'h23);
    check("t6_count", {29'd0, count}, 32'd3);
    tick();
    check("t6_data_pre", {24'd0, send_data}, 32'h20);
    rst_n = 1'b0;
    #1;
    check("t6_rst_count", {29'd0, count}, 32'd0);
    check("t6_rst_empty", {31'd0, empty}, 32'd1);
    check("t6_rst_full", {31'd0, full}, 32'd0);
    check("t6_rst_trig", {31'd0, send_trig}, 32'd0);
    check("t6_rst_data", {24'd0, send_data}, 32'h00);
    check("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    exp_q.push_back(8'h5A);
    write_byte(8'h5A);
    check("t6_count_after", {29'd0, count}, 32'd1);
    wait_idle();
    check("frames_left", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte buffer and send sequencer that sits directly upstream of the UART transmitter. It accepts bytes from the command/response logic into a power-of-two FIFO, then pops bytes one at a time. For each byte it issues a single-cycle send_trig/send_data pair and tracks the transmitter's tx_bsy handshake, so every queued byte becomes exactly one frame. Producers may burst writes without knowing the frame timing.

Parameters:
DEPTH, 16, number of byte entries; power of two, >= 2
CW, $clog2(DEPTH+1), width of the count output (derived; not overridden)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
wr_en  input  1  write strobe; one byte per cycle
wr_data  input  8  byte to enqueue
flush  input  1  synchronous clear of queued (not in-flight) bytes
full  output  1  FIFO holds DEPTH entries
empty  output  1  FIFO holds 0 entries
count  output  CW  number of queued entries, 0..DEPTH
overflow  output  1  one-cycle pulse when a write is dropped
send_trig  output  1  one-cycle request to transmitter
send_data  output  8  byte for transmitter; stable from the send_trig cycle until the next pop
tx_bsy  input  1  transmitter busy flag

Behaviour:
- One clock (clk). Reset is asynchronous, active-low (rst_n). All state is in flops with async clear.
- Reset values: send_trig=0, send_data=8'h00, count=0, empty=1, full=0, overflow=0, pointers=0, FSM=IDLE.
- full, empty and count are registered, or decoded purely from registered count. They reflect state after the last edge.
- Write: accepted when wr_en && !full && !flush. wr_data is stored at wr_ptr, and wr_ptr wraps modulo DEPTH.
- Write attempted when full: data is dropped and overflow=1 on the next cycle only. full is judged before any same-cycle pop, so a write while full is rejected even if a pop occurs that edge.
- Pop: head byte is registered into send_data, send_trig=1 for exactly one cycle, and rd_ptr wraps modulo DEPTH.
- Same-edge write and pop: count is unchanged.
- FSM states:
  - IDLE: if !empty && !tx_bsy, pop and go to TRIG.
  - TRIG: send_trig is high this cycle. Go to WAIT_BSY and drop send_trig next edge.
  - WAIT_BSY: wait for tx_bsy=1, then go to WAIT_DONE. The transmitter accepts a trig seen while tx_bsy=0, so this state is normally held for one cycle.
  - WAIT_DONE: wait for tx_bsy=0. On that edge, if !empty and !flush, pop and go straight to TRIG; otherwise go to IDLE.
- send_trig is never asserted while tx_bsy=1, and never on two consecutive cycles.
- Latency: wr_en at edge N into an empty, idle FIFO with tx_bsy=0 gives:
  - count=1 after edge N
  - send_trig=1 after edge N+1
  - transmitter tx_bsy=1 after edge N+2
- Back-to-back frames: the next send_trig asserts on the edge after tx_bsy is sampled low.
- flush: pointers and count clear to 0, empty=1, and any same-cycle write is dropped without an overflow pulse. A flush does not affect send_trig/send_data or FSM progress for a byte already popped, so the in-flight frame completes. A pop is suppressed on a flush cycle.
- rst_n asserted mid-frame: everything returns to reset values immediately. The transmitter is reset by the same rst_n.
- count arithmetic is CW bits wide and never exceeds DEPTH or underflows, since pop requires !empty and write requires !full.

Test Plan:
1. Reset with DEPTH=4, then hold idle -> empty=1, full=0, count=0, send_trig=0, send_data=8'h00.
2. Single write 8'hA5 with tx_bsy=0 -> count 1 after edge N, send_trig pulse of exactly 1 cycle after edge N+1 with send_data=8'hA5, count back to 0. The transmitter model emits one frame.
3. Burst-write 8'h01,8'h02,8'h03,8'h04 on four consecutive cycles -> full=1 at count=4, overflow never asserted. Frames go out in order 01,02,03,04, each send_trig issued only after tx_bsy falls, with no trig while tx_bsy=1.
4. With DEPTH=4 full and tx_bsy=1, write 8'hFF -> overflow=1 for one cycle, count stays 4, 8'hFF is never transmitted.
5. Queue 8'h10,8'h11,8'h12, then flush during the first frame -> the 8'h10 frame completes, count=0, empty=1, and no further send_trig.
6. Assert rst_n low mid-frame with count=3 -> all outputs return to reset values asynchronously. After release, a write of 8'h5A transmits normally.
